// File: rtl/uart_rx_cmd_parser.sv
// Turns a received byte stream into register write/read and ALU requests,
// and returns read data and ALU results as bytes on a valid/ready transmit port.
module uart_rx_cmd_parser #(
    parameter int unsigned dataWidth = 8,
    parameter int unsigned addrWidth = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [dataWidth-1:0]   rx_data,
    input  logic                   rx_valid,
    output logic                   wr_en,
    output logic                   rd_en,
    output logic [addrWidth-1:0]   addr,
    output logic [dataWidth-1:0]   wr_data,
    input  logic [dataWidth-1:0]   rd_data,
    input  logic                   rd_data_valid,
    output logic                   alu_en,
    output logic [dataWidth-1:0]   alu_a,
    output logic [dataWidth-1:0]   alu_b,
    output logic [3:0]             alu_fun,
    input  logic [2*dataWidth-1:0] alu_result,
    input  logic                   alu_valid,
    output logic [dataWidth-1:0]   tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   frame_err
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
    localparam logic [dataWidth-1:0] CmdWrite = dataWidth'(8'hAA);
    localparam logic [dataWidth-1:0] CmdRead  = dataWidth'(8'hBB);
    localparam logic [dataWidth-1:0] CmdAlu   = dataWidth'(8'hCC);
    localparam logic [CntWidth-1:0]  CntLast  = CntWidth'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_LO,
        S_TX_LAST
    } state_e;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [addrWidth-1:0] wr_addr_q, wr_addr_d;
    logic [dataWidth-1:0] res_hi_q, res_hi_d;
    logic [addrWidth-1:0] addr_q, addr_d;
    logic [dataWidth-1:0] wr_data_q, wr_data_d;
    logic [dataWidth-1:0] alu_a_q, alu_a_d;
    logic [dataWidth-1:0] alu_b_q, alu_b_d;
    logic [3:0]           alu_fun_q, alu_fun_d;
    logic [dataWidth-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;
    logic                 alu_en_q, alu_en_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 timed;
    logic                 tx_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_addr_q   <= '0;
            res_hi_q    <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            res_hi_q    <= res_hi_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            alu_en_q    <= alu_en_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        wr_addr_d   = wr_addr_q;
        res_hi_d    = res_hi_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_en_d    = 1'b0;
        frame_err_d = 1'b0;
        timed       = 1'b0;
        tx_hs       = tx_valid_q && tx_ready;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CmdWrite: state_d = S_WR_ADDR;
                        CmdRead:  state_d = S_RD_ADDR;
                        CmdAlu:   state_d = S_ALU_A;
                        default:  frame_err_d = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR: begin
                timed = 1'b1;
                if (rx_valid) begin
                    wr_addr_d = rx_data[addrWidth-1:0];
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                timed = 1'b1;
                if (rx_valid) begin
                    addr_d    = wr_addr_q;
                    wr_data_d = rx_data;
                    wr_en_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                timed = 1'b1;
                if (rx_valid) begin
                    addr_d  = rx_data[addrWidth-1:0];
                    rd_en_d = 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                timed       = 1'b1;
                frame_err_d = rx_valid;
                if (rd_data_valid) begin
                    tx_data_d  = rd_data;
                    tx_valid_d = 1'b1;
                    state_d    = S_TX_LAST;
                end
            end
            S_ALU_A: begin
                timed = 1'b1;
                if (rx_valid) begin
                    alu_a_d = rx_data;
                    state_d = S_ALU_B;
                end
            end
            S_ALU_B: begin
                timed = 1'b1;
                if (rx_valid) begin
                    alu_b_d = rx_data;
                    state_d = S_ALU_FUN;
                end
            end
            S_ALU_FUN: begin
                timed = 1'b1;
                if (rx_valid) begin
                    alu_fun_d = rx_data[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                timed       = 1'b1;
                frame_err_d = rx_valid;
                if (alu_valid) begin
                    tx_data_d  = alu_result[dataWidth-1:0];
                    res_hi_d   = alu_result[2*dataWidth-1:dataWidth];
                    tx_valid_d = 1'b1;
                    state_d    = S_TX_LO;
                end
            end
            S_TX_LO: begin
                frame_err_d = rx_valid;
                if (tx_hs) begin
                    tx_data_d = res_hi_q;
                    state_d   = S_TX_LAST;
                end
            end
            S_TX_LAST: begin
                frame_err_d = rx_valid;
                if (tx_hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A state change always restarts the count, so an event in the expiry cycle wins.
        if (timed && (state_d == state_q)) begin
            if (cnt_q == CntLast) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign alu_en    = alu_en_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Randomized scoreboard bench for uart_rx_cmd_parser: a frame-level model queues
// expected strobes and tx bytes, and an independent monitor checks them in order.
module tb_uart_rx_cmd_parser;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned TO = 16;

    localparam int EV_ERR = 1;
    localparam int EV_WR  = 2;
    localparam int EV_RD  = 3;
    localparam int EV_ALU = 4;
    localparam int EV_TX  = 5;

    typedef struct {
        int kind;
        int v0;
        int v1;
        int v2;
    } ev_t;

    typedef struct {
        int data;
        int delay;
    } resp_t;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   rx_data;
    logic            rx_valid;
    logic            wr_en;
    logic            rd_en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   rd_data;
    logic            rd_data_valid;
    logic            alu_en;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [3:0]      alu_fun;
    logic [2*DW-1:0] alu_result;
    logic            alu_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic            frame_err;

    ev_t   exp_q[$];
    resp_t rd_resp_q[$];
    resp_t alu_resp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ready_mode = 0;

    uart_rx_cmd_parser #(
        .dataWidth(DW),
        .addrWidth(AW),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .alu_en       (alu_en),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_fun      (alu_fun),
        .alu_result   (alu_result),
        .alu_valid    (alu_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [31:0] pack(int k, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        return {4'(k), 4'h0, a[7:0], b[7:0], c[7:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic take(string name, int k, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event 0x%0h, required none", name, pack(k, a, b, c));
        end else begin
            e = exp_q.pop_front();
            chk(name, pack(k, a, b, c), pack(e.kind, e.v0, e.v1, e.v2));
        end
    endtask

    task automatic expect_ev(int k, int a, int b, int c);
        ev_t e;
        e.kind = k;
        e.v0   = a;
        e.v1   = b;
        e.v2   = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe or tx handshake must match the head of the expected queue.
    initial begin : monitor
        logic          pv;
        logic [DW-1:0] pd;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (frame_err) take("frame_err", EV_ERR, 0, 0, 0);
                if (wr_en) take("wr_req", EV_WR, 32'(addr), 32'(wr_data), 0);
                if (rd_en) take("rd_req", EV_RD, 32'(addr), 0, 0);
                if (alu_en) take("alu_req", EV_ALU, 32'(alu_a), 32'(alu_b), 32'(alu_fun));
                if (tx_valid && tx_ready) take("tx_byte", EV_TX, 32'(tx_data), 0, 0);
                if (pv) chk("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, pd}));
                pv = tx_valid && !tx_ready;
                pd = tx_data;
            end
        end
    end

    initial begin : ready_gen
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'($urandom_range(0, 1));
                1:       tx_ready = 1'b0;
                default: tx_ready = 1'b1;
            endcase
        end
    end

    // Register-file model: answers each rd_en after a scripted delay; delay >= 100 means never.
    initial begin : rd_responder
        resp_t r;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        forever begin
            @(negedge clk);
            if (!rst && rd_en && rd_resp_q.size() > 0) begin
                r = rd_resp_q.pop_front();
                if (r.delay < 100) begin
                    repeat (r.delay) @(negedge clk);
                    rd_data       = DW'(r.data);
                    rd_data_valid = 1'b1;
                    @(negedge clk);
                    rd_data_valid = ($urandom_range(0, 3) == 0);
                    rd_data       = DW'($urandom);
                    @(negedge clk);
                    rd_data_valid = 1'b0;
                end
            end
        end
    end

    initial begin : alu_responder
        resp_t r;
        alu_valid  = 1'b0;
        alu_result = '0;
        forever begin
            @(negedge clk);
            if (!rst && alu_en && alu_resp_q.size() > 0) begin
                r = alu_resp_q.pop_front();
                repeat (r.delay) @(negedge clk);
                alu_result = (2*DW)'(r.data);
                alu_valid  = 1'b1;
                @(negedge clk);
                alu_valid  = ($urandom_range(0, 3) == 0);
                alu_result = (2*DW)'($urandom);
                @(negedge clk);
                alu_valid  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic send(int b);
        rx_data  = DW'(b);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = DW'($urandom);
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", budget);
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_strobes"}, 32'({wr_en, rd_en, alu_en, frame_err, tx_valid, busy}), 0);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_operands"}, 32'({wr_data, alu_a, alu_b}), 0);
        chk({tag, "_fun_tx"}, 32'({alu_fun, tx_data}), 0);
    endtask

    task automatic gap_maybe(int maxgap);
        idle($urandom_range(0, maxgap));
    endtask

    task automatic frame_write(int a, int d, int maxgap);
        expect_ev(EV_WR, a & 'hF, d, 0);
        send('hAA); gap_maybe(maxgap);
        send(a);    gap_maybe(maxgap);
        send(d);
    endtask

    task automatic frame_read(int a, int d, int dly, int maxgap);
        resp_t r;
        expect_ev(EV_RD, a & 'hF, 0, 0);
        expect_ev(EV_TX, d, 0, 0);
        r.data  = d;
        r.delay = dly;
        rd_resp_q.push_back(r);
        send('hBB); gap_maybe(maxgap);
        send(a);
    endtask

    task automatic frame_alu(int a, int b, int f, int res, int dly, int maxgap);
        resp_t r;
        expect_ev(EV_ALU, a, b, f & 'hF);
        expect_ev(EV_TX, res & 'hFF, 0, 0);
        expect_ev(EV_TX, (res >> 8) & 'hFF, 0, 0);
        r.data  = res;
        r.delay = dly;
        alu_resp_q.push_back(r);
        send('hCC); gap_maybe(maxgap);
        send(a);    gap_maybe(maxgap);
        send(b);    gap_maybe(maxgap);
        send(f);
    endtask

    task automatic frame_bad();
        int code;
        code = $urandom_range(0, 255);
        while (code == 'hAA || code == 'hBB || code == 'hCC) code = $urandom_range(0, 255);
        expect_ev(EV_ERR, 0, 0, 0);
        send(code);
    endtask

    initial begin : driver
        resp_t r;
        int    n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Write AA,05,3C.
        frame_write('h05, 'h3C, 0);
        chk("busy_at_wr_en", 32'(busy), 0);
        tick();
        chk("busy_after_wr", 32'(busy), 0);

        // Read BB,12 with the transmitter stalled.
        ready_mode = 1;
        frame_read('h12, 'h7E, 3, 0);
        n = 0;
        while (!tx_valid && n < 30) begin
            tick();
            n++;
        end
        chk("rd_tx_valid", 32'(tx_valid), 1);
        idle(5);
        chk("rd_tx_held", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h7E}));
        ready_mode = 2;
        wait_idle(20);
        ready_mode = 0;

        // ALU CC,10,20,00 with result 0x0130.
        ready_mode = 2;
        frame_alu('h10, 'h20, 'h00, 'h0130, 2, 0);
        wait_idle(40);
        ready_mode = 0;

        // Unknown code, then a normal write.
        expect_ev(EV_ERR, 0, 0, 0);
        send('h55);
        frame_write('h01, 'hFF, 0);
        wait_idle(10);

        // Write-data timeout: 3C then arrives in IDLE as an unknown command.
        expect_ev(EV_ERR, 0, 0, 0);
        expect_ev(EV_ERR, 0, 0, 0);
        send('hAA);
        send('h05);
        idle(TO);
        send('h3C);
        wait_idle(10);

        // Byte in the expiry cycle wins over the timeout.
        expect_ev(EV_WR, 'h5, 'h3C, 0);
        send('hAA);
        send('hF5);
        idle(TO - 1);
        send('h3C);
        wait_idle(10);

        // Read with no response times out in RD_WAIT.
        expect_ev(EV_RD, 'h3, 0, 0);
        expect_ev(EV_ERR, 0, 0, 0);
        r.data  = 0;
        r.delay = 200;
        rd_resp_q.push_back(r);
        send('hBB);
        send('h03);
        wait_idle(40);

        // Byte arriving while waiting for read data is dropped with an error.
        expect_ev(EV_RD, 'h9, 0, 0);
        expect_ev(EV_ERR, 0, 0, 0);
        expect_ev(EV_TX, 'hA5, 0, 0);
        r.data  = 'hA5;
        r.delay = 6;
        rd_resp_q.push_back(r);
        send('hBB);
        send('h39);
        idle(1);
        send('h11);
        wait_idle(60);

        // Asynchronous reset in ALU_B discards the frame.
        send('hCC);
        send('h10);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        idle(2);
        rst = 1'b0;
        idle(1);
        frame_alu('h5A, 'hC3, 'h07, 'hBEEF, 1, 1);
        wait_idle(60);

        // Random frame mix.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: frame_write($urandom_range(0, 255), $urandom_range(0, 255), 3);
                1: frame_read($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 5), 3);
                2: frame_alu($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                             $urandom_range(0, 65535), $urandom_range(0, 5), 3);
                default: frame_bad();
            endcase
            wait_idle(100);
            gap_maybe(2);
        end

        idle(10);
        chk("expected_queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
